// File: rtl/keypad_pkg.sv
// Shared state encoding, special key codes and the matrix-position-to-code map
// for the 4x4 keypad encoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   function automatic logic single_low(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, ~v[i]};
      return (n == 3'd1);
   endfunction

   // Only meaningful on a one-hot-low vector.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) if (!v[i]) idx = 2'(i);
      return idx;
   endfunction

   // Codes share the seven-segment nibble encoding, so digits display directly.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = KEY_STAR;
         4'hD:    code = 4'h0;
         4'hE:    code = KEY_HASH;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan-tick divider: counts 0..SCAN_DIV-1 and flags the last count.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [DW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == DW'(SCAN_DIV - 1));
   assign o_tick = w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_cnt <= '0;
      else if (w_last) r_cnt <= '0;
      else             r_cnt <= r_cnt + DW'(1);
   end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner: synchronizes rows, debounces one press and
// emits its code with a one-clock valid pulse.
//  state    | meaning
//  SCAN     | rotating columns, looking for a single low row on a tick
//  DEBOUNCE | column frozen, counting ticks the latched row stays low
//  HELD     | key accepted, counting all-high ticks until release
module keypad_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [3:0]    r_row_s1, r_row_s2;
   state_t        r_state, w_state_nx;
   logic [3:0]    r_col, w_col_nx;
   logic [3:0]    r_hit_row, w_hit_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
   logic [3:0]    r_key, w_key_nx;
   logic          r_valid, w_valid_nx;
   logic          r_held, w_held_nx;
   logic          w_tick;
   logic          w_cnt_done;

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_s1 <= 4'hF;
         r_row_s2 <= 4'hF;
      end else begin
         r_row_s1 <= row;
         r_row_s2 <= r_row_s1;
      end
   end

   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_cnt_done = (w_cnt_inc == CW'(DEBOUNCE_CYCLES));

   always_comb begin
      w_state_nx = r_state;
      w_col_nx   = r_col;
      w_hit_nx   = r_hit_row;
      w_cnt_nx   = r_cnt;
      w_key_nx   = r_key;
      w_valid_nx = 1'b0;
      w_held_nx  = r_held;
      if (w_tick) begin
         unique case (r_state)
            SCAN: begin
               if (single_low(r_row_s2)) begin
                  w_hit_nx   = r_row_s2;
                  w_cnt_nx   = '0;
                  w_state_nx = DEBOUNCE;
               end else begin
                  w_col_nx = {r_col[2:0], r_col[3]};
               end
            end
            DEBOUNCE: begin
               if (r_row_s2 == r_hit_row) begin
                  if (w_cnt_done) begin
                     w_key_nx   = key_code(low_index(r_hit_row), low_index(r_col));
                     w_valid_nx = 1'b1;
                     w_held_nx  = 1'b1;
                     w_cnt_nx   = '0;
                     w_state_nx = HELD;
                  end else begin
                     w_cnt_nx = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nx   = '0;
                  w_col_nx   = {r_col[2:0], r_col[3]};
                  w_state_nx = SCAN;
               end
            end
            HELD: begin
               // A second key in the frozen column also keeps rs off all-high.
               if (r_row_s2 == 4'hF) begin
                  if (w_cnt_done) begin
                     w_held_nx  = 1'b0;
                     w_cnt_nx   = '0;
                     w_state_nx = SCAN;
                  end else begin
                     w_cnt_nx = w_cnt_inc;
                  end
               end else begin
                  w_cnt_nx = '0;
               end
            end
            default: w_state_nx = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= SCAN;
         r_col     <= 4'b1110;
         r_hit_row <= 4'hF;
         r_cnt     <= '0;
         r_key     <= 4'h0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_col     <= w_col_nx;
         r_hit_row <= w_hit_nx;
         r_cnt     <= w_cnt_nx;
         r_key     <= w_key_nx;
         r_valid   <= w_valid_nx;
         r_held    <= w_held_nx;
      end
   end

   assign col       = r_col;
   assign key       = r_key;
   assign key_valid = r_valid;
   assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad matrix model drives rows from col, and a
// tick-level behavioural model predicts col/key/key_valid/key_held every cycle.
module tb_keypad_encoder;

   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;
   int p0;
   int changes;
   int nk;
   logic [3:0]  prev_col;
   logic [15:0] rp;

   keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if ((pressed[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
   end

   // Behavioural reference: integer column index, tick counter and stability count.
   logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
   int         m_div, m_col, m_mode, m_n, m_hit;
   logic [3:0] m_s1, m_s2, m_raw, m_rs, m_key, m_exp_col;
   logic       m_valid, m_held;

   function automatic int lows(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!v[i]) n++;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_div = 0; m_col = 0; m_mode = 0; m_n = 0; m_hit = 0;
         m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
      end else begin
         m_raw = 4'hF;
         for (int r = 0; r < 4; r++) if (pressed[r*4 + m_col]) m_raw[r] = 1'b0;
         m_rs    = m_s2;
         m_valid = 1'b0;
         if (m_div == SD - 1) begin
            if (m_mode == 0) begin
               if (lows(m_rs) == 1) begin
                  for (int r = 0; r < 4; r++) if (!m_rs[r]) m_hit = r;
                  m_mode = 1;
                  m_n    = 0;
               end else begin
                  m_col = (m_col + 1) % 4;
               end
            end else if (m_mode == 1) begin
               if (lows(m_rs) == 1 && !m_rs[m_hit]) begin
                  m_n++;
                  if (m_n == DB) begin
                     m_key = keymap[m_hit*4 + m_col];
                     m_valid = 1'b1; m_held = 1'b1; m_n = 0; m_mode = 2;
                  end
               end else begin
                  m_n = 0; m_mode = 0; m_col = (m_col + 1) % 4;
               end
            end else begin
               if (m_rs == 4'hF) begin
                  m_n++;
                  if (m_n == DB) begin
                     m_held = 1'b0; m_n = 0; m_mode = 0;
                  end
               end else begin
                  m_n = 0;
               end
            end
         end
         m_div = (m_div + 1) % SD;
         m_s2  = m_s1;
         m_s1  = m_raw;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_exp_col = ~(4'b0001 << m_col);
         check("col", int'(col), int'(m_exp_col));
         check("key", int'(key), int'(m_key));
         check("key_valid", int'(key_valid), int'(m_valid));
         check("key_held", int'(key_held), int'(m_held));
         if (key_valid) n_pulses++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_held(input logic v, input int limit, input string name);
      int i = 0;
      while (key_held !== v && i < limit) begin
         @(negedge clk);
         i++;
      end
      #1;
      check(name, int'(key_held), int'(v));
   endtask

   task automatic wait_col(input logic [3:0] v, input int limit, input string name);
      int i = 0;
      while (col !== v && i < limit) begin
         @(negedge clk);
         i++;
      end
      #1;
      check(name, int'(col), int'(v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      check("reset_col", int'(col), 4'hE);
      check("reset_key", int'(key), 0);
      check("reset_valid", int'(key_valid), 0);
      check("reset_held", int'(key_held), 0);
      cycles(3);
      @(negedge clk) rst = 1'b0;
      #1;

      // '5' at r1/c1
      p0 = n_pulses;
      pressed = 16'h0020;
      wait_held(1'b1, 80, "press5_held");
      check("press5_key", int'(key), 5);
      check("press5_model_key", int'(m_key), 5);
      check("press5_col", int'(col), 4'hD);
      check("press5_pulses", n_pulses - p0, 1);
      cycles(40);
      check("press5_no_repeat", n_pulses - p0, 1);
      pressed = 16'h0000;
      wait_held(1'b0, 40, "release5");
      check("release5_col_frozen", int'(col), 4'hD);
      wait_col(4'b1011, 12, "release5_rotates");

      // '9' at r2/c2 with a bounce in the middle of debounce
      p0 = n_pulses;
      wait_col(4'b0111, 20, "bounce_sync0");
      wait_col(4'b1011, 20, "bounce_sync1");
      pressed = 16'h0400;
      cycles(12);
      check("bounce_no_early_pulse", n_pulses - p0, 0);
      pressed = 16'h0000;
      cycles(4);
      check("bounce_still_none", n_pulses - p0, 0);
      pressed = 16'h0400;
      wait_held(1'b1, 100, "bounce_held");
      check("bounce_key", int'(key), 9);
      check("bounce_pulses", n_pulses - p0, 1);
      pressed = 16'h0000;
      wait_held(1'b0, 60, "bounce_release");

      // ghosting: '1' and '4' together on c0
      p0 = n_pulses;
      pressed = 16'h0011;
      changes = 0;
      prev_col = col;
      repeat (48) begin
         @(negedge clk);
         if (col != prev_col) changes++;
         prev_col = col;
      end
      #1;
      check("ghost_no_pulse", n_pulses - p0, 0);
      check("ghost_rotates", int'(changes >= 10), 1);
      pressed = 16'h0000;

      // long hold of '#', with '3' (same column) pressed during the hold
      p0 = n_pulses;
      pressed = 16'h4000;
      wait_held(1'b1, 100, "hash_held");
      check("hash_key", int'(key), 15);
      check("hash_model_key", int'(m_key), 15);
      cycles(200);
      pressed = 16'h4004;
      cycles(100);
      pressed = 16'h4000;
      cycles(100);
      check("hash_one_pulse", n_pulses - p0, 1);
      check("hash_key_kept", int'(key), 15);
      pressed = 16'h0004;
      cycles(40);
      check("same_col_blocks_release", int'(key_held), 1);
      pressed = 16'h0000;
      wait_held(1'b0, 60, "hash_release");

      // reset while debouncing 'A' at r0/c3
      p0 = n_pulses;
      wait_col(4'b1110, 20, "a_sync0");
      pressed = 16'h0008;
      wait_col(4'b0111, 20, "a_sync1");
      cycles(6);
      check("a_in_debounce_col", int'(col), 4'h7);
      check("a_in_debounce_held", int'(key_held), 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_col", int'(col), 4'hE);
      check("midrst_key", int'(key), 0);
      check("midrst_valid", int'(key_valid), 0);
      check("midrst_held", int'(key_held), 0);
      pressed = 16'h0000;
      cycles(3);
      @(negedge clk) rst = 1'b0;
      #1;
      cycles(40);
      check("midrst_no_pulse", n_pulses - p0, 0);
      check("midrst_key_zero", int'(key), 0);
      pressed = 16'h0008;
      wait_held(1'b1, 100, "a_held");
      check("a_key", int'(key), 10);
      check("a_pulses", n_pulses - p0, 1);
      pressed = 16'h0000;
      wait_held(1'b0, 60, "a_release");

      // randomized key patterns, checked cycle by cycle against the model
      for (int it = 0; it < 40; it++) begin
         rp = 16'h0000;
         nk = int'($urandom_range(0, 2));
         for (int k = 0; k < nk; k++) rp[$urandom_range(0, 15)] = 1'b1;
         pressed = rp;
         cycles(int'($urandom_range(1, 60)));
      end
      pressed = 16'h0000;
      wait_held(1'b0, 100, "random_final_release");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
